fir_tap_loader: RTL and testbench
=================================

# fir_tap_loader

Tap-stream initiator for the configurable FIR tap port used by the reverb and FIR wrappers. Software writes coefficients into a local staging array at any time. A single `load_start` pulse then streams all 2**G_NUM_TAPS_LOG2 taps, address 0 first, over a valid/ready handshake. The block then waits for the FIR's tap-done indication and reports completion.

## Interface
- `G_TAP_WIDTH`, 16: tap word width; must match the FIR's G_TAP_WIDTH.
- `G_NUM_TAPS_LOG2`, 4: log2 tap count; must equal the FIR's G_NUM_STAGES_LOG2 + G_STAGE_DEPTH_LOG2.
- `G_DONE_TIMEOUT`, 1024: wait-for-done limit in cycles; used only with the timeout macro.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  sole clock.
- `reset`  in  1  async active-high reset.
- `enable`  in  1  0 = synchronous return to IDLE; staging contents kept.
- `wr_addr`  in  G_NUM_TAPS_LOG2  staging write address.
- `wr_data`  in  G_TAP_WIDTH  staging write data.
- `wr_en`  in  1  staging write strobe.
- `load_start`  in  1  start-load pulse.
- `busy`  out  1  high from accepted start until done.
- `load_done`  out  1  one-cycle completion pulse.
- `load_error`  out  1  sticky timeout flag.
- `tap_dout`  out  G_TAP_WIDTH  tap word to the FIR `tap_din`.
- `tap_dout_valid`  out  1  tap valid.
- `tap_dout_ready`  in  1  FIR `tap_din_ready`.
- `tap_dout_done`  in  1  FIR `tap_din_done`.

## Operation
- States:
  - IDLE: accept `load_start` when `enable`=1. Clear `rd_ptr`; go to STREAM.
  - STREAM: present `tap[rd_ptr]`. On each valid&ready, increment `rd_ptr`. When the handshake occurs at `rd_ptr`=N-1, go to WAIT_DONE.
  - WAIT_DONE: when `tap_dout_done`=1, pulse `load_done` and return to IDLE.
- Staging array: register array, N x G_TAP_WIDTH, cleared to 0 by reset.
  - `wr_en` writes in IDLE only; writes while `busy` are dropped.
  - The streamed set is therefore exactly the contents at `load_start`.
- `load_start` while `busy` or while `enable`=0 is ignored.
- `enable`=0 in any state: next cycle state is IDLE and `busy`, `tap_dout_valid` and `load_done` are 0. `load_error` is retained and the staging array is kept.
- `tap_dout` is unchanged while valid&!ready (AXIS stability). `tap_dout_valid` never drops without a handshake, except on `enable`=0 or reset.
- `rd_ptr` is G_NUM_TAPS_LOG2+1 bits wide, so it does not wrap before the final compare.
- `load_error` clears on the next accepted `load_start`.

## Timing
- Reset values: `busy`=0, `load_done`=0, `load_error`=0, `tap_dout_valid`=0, `tap_dout`=0, state IDLE.
- `load_start` sampled high at edge k: `busy`=1 and `tap_dout_valid`=1 with `tap[0]` after edge k.
- Throughput is one tap per cycle with `tap_dout_ready` held high. N taps occupy N consecutive cycles.
- After the last handshake, `tap_dout_valid`=0 on the next cycle.
- `tap_dout_done` already high on the first WAIT_DONE cycle: `load_done` pulses one cycle later.
- `load_done` and the `busy` fall are registered and coincide: `busy`=0 in the same cycle `load_done`=1.
- A new `load_start` is accepted in the cycle `load_done` is high.
- `wr_en` and `load_start` in the same IDLE cycle: the write lands first, so the new value is streamed.

## Configuration
- `TAP_LOADER_DONE_TIMEOUT_EN` defined:
  - A WAIT_DONE cycle counter runs.
  - If it reaches G_DONE_TIMEOUT with no `tap_dout_done`: set `load_error`, pulse `load_done`, return to IDLE.
- Undefined: WAIT_DONE waits indefinitely; `load_error` is tied to 0 and G_DONE_TIMEOUT is unused.

## Structure
- Shared package `tulip_tap_pkg`:
  - state enum typedef (IDLE, STREAM, WAIT_DONE);
  - timeout-counter width constant ($clog2(G_DONE_TIMEOUT+1)).
- One sub-module, `tap_staging_regs`: reset-clearable register array with a write port and a combinational read port.
- FSM, pointer and output register stay in the top.

## Test plan
- Default params; write taps 0..15 with values 0x0100+i; `load_start`; ready held high; FIR raises done 2 cycles after the last tap.
  - Required: 16 consecutive beats 0x0100..0x010F.
  - `load_done` pulses 3 cycles after the last beat; `busy` spans start+1 to `load_done`.
- Random `tap_dout_ready` at 30% duty.
  - Required: identical beat order.
  - `tap_dout` stable whenever valid&!ready.
  - No extra or missing beats.
- Write to addr 5 (0xBEEF) during STREAM.
  - Required: the stream carries the old value.
  - The next load carries the old value too, because the write was dropped.
- `enable`=0 after beat 7.
  - Required: next cycle `busy`=0, valid=0.
  - A re-enabled `load_start` streams all 16 taps from `tap[0]`.
- Assert `reset` mid-STREAM, asynchronously between edges.
  - Required: outputs go to reset values immediately.
  - The staging array reads back 0.
- With `TAP_LOADER_DONE_TIMEOUT_EN` and G_DONE_TIMEOUT=8; done never asserted.
  - Required: `load_done` with `load_error`=1 eight cycles into WAIT_DONE.
  - `load_error` clears on the next `load_start`.
  - Without the macro, the same stimulus leaves `busy` high indefinitely.

Source files
------------

// File: rtl/tulip_tap_pkg.sv
// Shared types and constants for the FIR tap loader.
package tulip_tap_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } tap_state_e;

    // Width of a counter that must be able to hold the value `timeout`.
    function automatic int tmo_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int DEFAULT_DONE_TIMEOUT = 1024;
    localparam int DEFAULT_TMO_CNT_W    = tmo_cnt_width(DEFAULT_DONE_TIMEOUT);

endpackage

// File: rtl/tap_staging_regs.sv
// Coefficient staging array: reset-clearable registers, one write port,
// combinational read port.
module tap_staging_regs #(
    parameter int G_TAP_WIDTH     = 16,
    parameter int G_NUM_TAPS_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [G_NUM_TAPS_LOG2-1:0] wr_addr,
    input  logic [G_TAP_WIDTH-1:0]     wr_data,
    input  logic [G_NUM_TAPS_LOG2-1:0] rd_addr,
    output logic [G_TAP_WIDTH-1:0]     rd_data
);

    localparam int N_TAPS = 2 ** G_NUM_TAPS_LOG2;

    logic [G_TAP_WIDTH-1:0] taps_q [N_TAPS];

    // NOTE: built from flops rather than a RAM macro, so every entry can be
    // cleared by reset and the array reads back zero after a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_TAPS; i++) begin
                taps_q[i] <= '0;
            end
        end else if (wr_en) begin
            taps_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = taps_q[rd_addr];

endmodule

// File: rtl/fir_tap_loader.sv
// Streams the staged FIR taps over valid/ready, then waits for the FIR's done.
// Optional wait-for-done timeout: define TAP_LOADER_DONE_TIMEOUT_EN.
module fir_tap_loader
    import tulip_tap_pkg::*;
#(
    parameter int G_TAP_WIDTH     = 16,
    parameter int G_NUM_TAPS_LOG2 = 4,
    parameter int G_DONE_TIMEOUT  = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [G_NUM_TAPS_LOG2-1:0] wr_addr,
    input  logic [G_TAP_WIDTH-1:0]     wr_data,
    input  logic                       wr_en,
    input  logic                       load_start,
    output logic                       busy,
    output logic                       load_done,
    output logic                       load_error,
    output logic [G_TAP_WIDTH-1:0]     tap_dout,
    output logic                       tap_dout_valid,
    input  logic                       tap_dout_ready,
    input  logic                       tap_dout_done
);

    localparam int N_TAPS = 2 ** G_NUM_TAPS_LOG2;
    localparam int PTR_W  = G_NUM_TAPS_LOG2 + 1;

    tap_state_e             state_q, state_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_inc;
    logic [G_TAP_WIDTH-1:0] tap_dout_q, tap_dout_d;
    logic                   load_done_q, load_done_d;

    logic                       stg_wr_en;
    logic [G_NUM_TAPS_LOG2-1:0] stg_rd_addr;
    logic [G_TAP_WIDTH-1:0]     stg_rd_data;
    logic [G_TAP_WIDTH-1:0]     first_tap;
    logic                       start_accept;
    logic                       timeout_hit;

    // The output register is always loaded one tap ahead, so the array is
    // read at tap 0 while idle and at rd_ptr+1 while streaming.
    assign rd_ptr_inc  = rd_ptr_q + PTR_W'(1);
    assign stg_rd_addr = (state_q == IDLE) ? '0 : rd_ptr_inc[G_NUM_TAPS_LOG2-1:0];
    assign stg_wr_en   = wr_en && (state_q == IDLE);

    // A write to tap 0 in the start cycle must reach the first beat.
    assign first_tap    = (stg_wr_en && (wr_addr == '0)) ? wr_data : stg_rd_data;
    assign start_accept = enable && (state_q == IDLE) && load_start;

    tap_staging_regs #(
        .G_TAP_WIDTH     (G_TAP_WIDTH),
        .G_NUM_TAPS_LOG2 (G_NUM_TAPS_LOG2)
    ) u_staging (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (stg_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (stg_rd_addr),
        .rd_data (stg_rd_data)
    );

`ifdef TAP_LOADER_DONE_TIMEOUT_EN
    localparam int CNT_W = tmo_cnt_width(G_DONE_TIMEOUT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             load_error_q, load_error_d;

    assign timeout_hit = (wait_cnt_q + CNT_W'(1)) == CNT_W'(G_DONE_TIMEOUT);
    assign wait_cnt_d  = (state_q == WAIT_DONE) ? wait_cnt_q + CNT_W'(1) : '0;

    always_comb begin
        load_error_d = load_error_q;
        if (start_accept) begin
            load_error_d = 1'b0;
        end else if (enable && (state_q == WAIT_DONE) && !tap_dout_done && timeout_hit) begin
            load_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q   <= '0;
            load_error_q <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            load_error_q <= load_error_d;
        end
    end

    assign load_error = load_error_q;
`else
    logic [31:0] done_timeout_unused;

    assign done_timeout_unused = 32'(G_DONE_TIMEOUT);
    assign timeout_hit         = 1'b0;
    assign load_error          = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        tap_dout_d  = tap_dout_q;
        load_done_d = 1'b0;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_d    = STREAM;
                        rd_ptr_d   = '0;
                        tap_dout_d = first_tap;
                    end
                end
                STREAM: begin
                    if (tap_dout_ready) begin
                        rd_ptr_d   = rd_ptr_inc;
                        tap_dout_d = stg_rd_data;
                        if (rd_ptr_q == PTR_W'(N_TAPS - 1)) begin
                            state_d = WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (tap_dout_done || timeout_hit) begin
                        state_d     = IDLE;
                        load_done_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            tap_dout_q  <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            tap_dout_q  <= tap_dout_d;
            load_done_q <= load_done_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign tap_dout_valid = (state_q == STREAM);
    assign load_done      = load_done_q;
    assign tap_dout       = tap_dout_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader: tap streaming, backpressure, dropped
// writes, enable abort, async reset, and the optional done timeout.
module tb_fir_tap_loader;

    localparam int W   = 16;
    localparam int AW  = 4;
    localparam int N   = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          wr_en;
    logic          load_start;
    logic          busy;
    logic          load_done;
    logic          load_error;
    logic [W-1:0]  tap_dout;
    logic          tap_dout_valid;
    logic          tap_dout_ready;
    logic          tap_dout_done;

    fir_tap_loader #(
        .G_TAP_WIDTH     (W),
        .G_NUM_TAPS_LOG2 (AW),
        .G_DONE_TIMEOUT  (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .load_start     (load_start),
        .busy           (busy),
        .load_done      (load_done),
        .load_error     (load_error),
        .tap_dout       (tap_dout),
        .tap_dout_valid (tap_dout_valid),
        .tap_dout_ready (tap_dout_ready),
        .tap_dout_done  (tap_dout_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [W-1:0]  exp_beat;
    } tap_vec_t;

    tap_vec_t     vecs [N];
    logic [W-1:0] model [N];
    logic [W-1:0] beats [$];
    int           checks   = 0;
    int           failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        next_cycle();
        load_start = 1'b0;
    endtask

    // Drives ready at the given duty until n_beats handshakes are seen.
    task automatic capture(input int ready_pct, input int n_beats, output int cycles);
        logic         held_v;
        logic [W-1:0] held;
        held_v = 1'b0;
        held   = '0;
        cycles = 0;
        beats.delete();
        while (beats.size() < n_beats && cycles < 1000) begin
            tap_dout_ready = ($urandom_range(99, 0) < ready_pct);
            @(negedge clk);
            check("busy_stream", busy, 1);
            if (held_v) begin
                check("valid_held", tap_dout_valid, 1);
                check("tap_stable", tap_dout, held);
            end
            if (tap_dout_valid && tap_dout_ready) begin
                beats.push_back(tap_dout);
                held_v = 1'b0;
            end else begin
                held_v = tap_dout_valid;
                held   = tap_dout;
            end
            next_cycle();
            wr_en = 1'b0;
            cycles++;
        end
        tap_dout_ready = 1'b0;
        check("beat_count", 32'(beats.size()), 32'(n_beats));
    endtask

    task automatic verify_beats(input string name);
        for (int i = 0; i < N; i++) begin
            if (i < beats.size()) check(name, beats[i], model[i]);
        end
    endtask

    task automatic wait_load_done(input int bound);
        int n = 0;
        while (!load_done && n < bound) begin
            next_cycle();
            n++;
        end
        check("load_done_seen", load_done, 1);
        check("busy_at_done", busy, 0);
    endtask

    task automatic finish_load();
        tap_dout_done = 1'b1;
        wait_load_done(20);
        tap_dout_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset          = 1'b1;
        enable         = 1'b1;
        wr_addr        = '0;
        wr_data        = '0;
        wr_en          = 1'b0;
        load_start     = 1'b0;
        tap_dout_ready = 1'b0;
        tap_dout_done  = 1'b0;

        // Taps are written in descending address order; beats come out ascending.
        for (int i = 0; i < N; i++) begin
            vecs[i].addr     = AW'(N - 1 - i);
            vecs[i].data     = 16'h010F - 16'(i);
            vecs[i].exp_beat = 16'h0100 + 16'(i);
            model[i]         = vecs[i].exp_beat;
        end

        next_cycle();
        next_cycle();
        check("rst_busy", busy, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_error", load_error, 0);
        check("rst_valid", tap_dout_valid, 0);
        check("rst_tap_dout", tap_dout, 0);
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < N; i++) begin
            wr_en   = 1'b1;
            wr_addr = vecs[i].addr;
            wr_data = vecs[i].data;
            next_cycle();
        end
        wr_en = 1'b0;

        // Full-rate stream; done raised two cycles after the last beat.
        start_load();
        capture(100, N, cyc);
        check("stream_cycles", 32'(cyc), 32'(N));
        for (int i = 0; i < N; i++) begin
            if (i < beats.size()) check("beat_table", beats[i], vecs[i].exp_beat);
        end
        @(negedge clk);
        check("valid_after_last", tap_dout_valid, 0);
        check("busy_wait_done", busy, 1);
        next_cycle();
        tap_dout_done = 1'b1;
        @(negedge clk);
        check("done_not_yet", load_done, 0);
        next_cycle();
        tap_dout_done = 1'b0;
        @(negedge clk);
        check("done_plus3", load_done, 1);
        check("busy_fall", busy, 0);

        // Restart in the load_done cycle, then stream with 30% ready.
        load_start = 1'b1;
        next_cycle();
        load_start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_valid", tap_dout_valid, 1);
        check("restart_first", tap_dout, 16'h0100);
        check("restart_done_low", load_done, 0);
        capture(30, N, cyc);
        verify_beats("beat_bp");
        @(negedge clk);
        check("no_extra_beat", tap_dout_valid, 0);
        finish_load();

        // Write during STREAM is dropped.
        start_load();
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 16'hBEEF;
        capture(100, N, cyc);
        verify_beats("beat_drop_wr");
        finish_load();
        start_load();
        capture(100, N, cyc);
        verify_beats("beat_after_drop");
        finish_load();

        // load_start with enable low is ignored.
        enable     = 1'b0;
        load_start = 1'b1;
        next_cycle();
        load_start = 1'b0;
        enable     = 1'b1;
        @(negedge clk);
        check("start_disabled", busy, 0);
        next_cycle();

        // Abort with enable=0 after beat 7, then a clean full load.
        start_load();
        capture(100, 8, cyc);
        enable = 1'b0;
        next_cycle();
        check("abort_busy", busy, 0);
        check("abort_valid", tap_dout_valid, 0);
        check("abort_done", load_done, 0);
        enable = 1'b1;
        start_load();
        capture(100, N, cyc);
        verify_beats("beat_reenable");
        finish_load();

        // Write and start in the same cycle: the new tap 0 is streamed.
        wr_en      = 1'b1;
        wr_addr    = 4'd0;
        wr_data    = 16'h1234;
        load_start = 1'b1;
        next_cycle();
        wr_en      = 1'b0;
        load_start = 1'b0;
        model[0]   = 16'h1234;
        capture(100, N, cyc);
        verify_beats("beat_wr_first");
        finish_load();

        // Async reset between edges mid-stream.
        start_load();
        capture(100, 4, cyc);
        #3 reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", tap_dout_valid, 0);
        check("arst_tap_dout", tap_dout, 0);
        check("arst_load_done", load_done, 0);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;
        next_cycle();
        start_load();
        capture(100, N, cyc);
        verify_beats("beat_after_rst");

`ifdef TAP_LOADER_DONE_TIMEOUT_EN
        // Done never arrives: timeout after TMO WAIT_DONE cycles.
        for (int j = 0; j < TMO; j++) begin
            @(negedge clk);
            check("tmo_not_yet", load_done, 0);
            next_cycle();
        end
        @(negedge clk);
        check("tmo_done", load_done, 1);
        check("tmo_error", load_error, 1);
        check("tmo_busy", busy, 0);
        next_cycle();
        check("tmo_error_sticky", load_error, 1);
        check("tmo_done_pulse", load_done, 0);
        start_load();
        check("tmo_error_clr", load_error, 0);
        capture(100, N, cyc);
        finish_load();
`else
        // Done never arrives: the loader waits indefinitely.
        begin
            logic saw_done = 1'b0;
            for (int j = 0; j < 5 * TMO; j++) begin
                next_cycle();
                if (load_done) saw_done = 1'b1;
            end
            check("no_tmo_busy", busy, 1);
            check("no_tmo_done", saw_done, 0);
            check("no_tmo_error", load_error, 0);
        end
        enable = 1'b0;
        next_cycle();
        enable = 1'b1;
        check("no_tmo_abort", busy, 0);
`endif

        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
